// File: rtl/dffs_response_checker.sv
// Response checker for set-type D flip-flop cells (D, SN, CK -> Q, QN).
// Accepts one stimulus vector per handshake, waits for the cell to settle,
// then compares Q/QN against a behavioural model of the cell.
module dffs_response_checker #(
    parameter int unsigned NUM_VEC = 8,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned ERR_W   = 4
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic             vec_d,
    input  logic             vec_sn,
    input  logic             vec_ck,
    input  logic             dut_q,
    input  logic             dut_qn,
    output logic             exp_q,
    output logic             exp_known,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       vec_count,
    output logic             done,
    output logic             pass
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned VC_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_VEC,
        ST_SETTLE,
        ST_COMPARE,
        ST_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   settle_cnt, settle_cnt_nxt;
    logic               prev_ck, prev_ck_nxt;
    logic               vec_ready_nxt;
    logic               exp_q_nxt;
    logic               exp_known_nxt;
    logic               err_pulse_nxt;
    logic [ERR_W-1:0]   err_count_nxt;
    logic [VC_W-1:0]    vec_count_nxt;
    logic               done_nxt;
    logic               pass_nxt;
    logic               accept_c;
    logic               mismatch_c;

    // Handshake and compare qualifiers; the complement check ignores model state.
    assign accept_c   = vec_valid && vec_ready;
    assign mismatch_c = (exp_known && (dut_q != exp_q)) || (dut_qn == dut_q);

    // Next-state, model update and counter logic.
    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        prev_ck_nxt    = prev_ck;
        vec_ready_nxt  = 1'b0;
        exp_q_nxt      = exp_q;
        exp_known_nxt  = exp_known;
        err_pulse_nxt  = 1'b0;
        err_count_nxt  = err_count;
        vec_count_nxt  = vec_count;
        done_nxt       = done;
        pass_nxt       = pass;

        if (start) begin
            // New run from any state; a vector offered this cycle is dropped.
            state_nxt      = ST_WAIT_VEC;
            settle_cnt_nxt = '0;
            prev_ck_nxt    = 1'b1;
            vec_ready_nxt  = 1'b1;
            exp_q_nxt      = 1'b0;
            exp_known_nxt  = 1'b0;
            err_count_nxt  = '0;
            vec_count_nxt  = '0;
            done_nxt       = 1'b0;
            pass_nxt       = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                end
                ST_WAIT_VEC: begin
                    vec_ready_nxt = 1'b1;
                    if (accept_c) begin
                        if (!vec_sn) begin
                            exp_q_nxt     = 1'b1;
                            exp_known_nxt = 1'b1;
                        end else if (!prev_ck && vec_ck) begin
                            exp_q_nxt     = vec_d;
                            exp_known_nxt = 1'b1;
                        end
                        prev_ck_nxt    = vec_ck;
                        settle_cnt_nxt = '0;
                        vec_ready_nxt  = 1'b0;
                        state_nxt      = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == CNT_W'(SETTLE - 1)) begin
                        state_nxt = ST_COMPARE;
                    end else begin
                        settle_cnt_nxt = settle_cnt + CNT_W'(1);
                    end
                end
                ST_COMPARE: begin
                    if (mismatch_c) begin
                        err_pulse_nxt = 1'b1;
                        if (err_count != {ERR_W{1'b1}}) begin
                            err_count_nxt = err_count + ERR_W'(1);
                        end
                    end
                    vec_count_nxt = vec_count + VC_W'(1);
                    if (vec_count_nxt == VC_W'(NUM_VEC)) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                        pass_nxt  = (err_count_nxt == '0);
                    end else begin
                        state_nxt     = ST_WAIT_VEC;
                        vec_ready_nxt = 1'b1;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            prev_ck    <= 1'b1;
            vec_ready  <= 1'b0;
            exp_q      <= 1'b0;
            exp_known  <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            vec_count  <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            prev_ck    <= prev_ck_nxt;
            vec_ready  <= vec_ready_nxt;
            exp_q      <= exp_q_nxt;
            exp_known  <= exp_known_nxt;
            err_pulse  <= err_pulse_nxt;
            err_count  <= err_count_nxt;
            vec_count  <= vec_count_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
        end
    end

endmodule
